reg_file_32x32: RTL



---
 rtl/reg_file_32x32.sv | 82 ++++++++
 1 files changed

// File: rtl/reg_file_32x32.sv
// ---------------------------------------------------------------------------
// reg_file_32x32
// MIPS general-purpose register file: 2**ADDR_WIDTH registers of DATA_WIDTH
// bits, two combinational read ports and one clocked write port.
// Register 0 is hard-wired to zero. A write presented in the current cycle is
// forwarded to any read port addressing the same register, so a dependent read
// in the write-back cycle sees the new value.
//
// Ports:
//   clk       rising-edge clock for all state updates
//   rst       asynchronous active-high reset, clears every register
//   rd_addr1  read port 1 index (rs)        rd_data1  read port 1 data
//   rd_addr2  read port 2 index (rt)        rd_data2  read port 2 data
//   wr_en     write enable (RegWrite)
//   wr_addr   write index
//   wr_data   write data (write-back select output)
// ---------------------------------------------------------------------------
module reg_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    // Entry 0 is never written and never read; it is held at zero so the
    // array can be indexed directly by the address.
    logic [DATA_WIDTH-1:0] regs [NREGS];

    logic wr_ok;
    assign wr_ok = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read priority: reset and register 0 force zero, then the in-flight
    // write, then stored contents.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  in_rst,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  in_wr_en,
        input logic [ADDR_WIDTH-1:0] in_wr_addr,
        input logic [DATA_WIDTH-1:0] in_wr_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] val;
        val = stored;
        if (in_rst || (addr == '0)) begin
            val = '0;
        end else if (in_wr_en && (in_wr_addr == addr)) begin
            val = in_wr_data;
        end
        return val;
    endfunction

    always_comb begin
        rd_data1 = '0;
        rd_data1 = read_port(rst, rd_addr1, wr_en, wr_addr, wr_data, regs[rd_addr1]);
    end

    always_comb begin
        rd_data2 = '0;
        rd_data2 = read_port(rst, rd_addr2, wr_en, wr_addr, wr_data, regs[rd_addr2]);
    end

endmodule
